uart_ctrl: RTL
==============

Name: uart_ctrl

Overview:
Parametrised full-duplex UART. It generalises the fixed 8N1 uart_top to configurable data width, parity, stop bits and an oversampled receiver with framing and parity error reporting. It sits between a byte-stream client (valid/ready on TX, valid pulse on RX) and the serial pins. TX and RX run independently off one shared oversample tick.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, number of stop bits, 1 or 2
OVERSAMPLE, 16, oversample ticks per bit, even, ≥8

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_data  in  DATA_BITS  word to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  transmitter can accept a word
tx  out  1  serial output, idle high
tx_done  out  1  one-cycle pulse when the last stop bit completes
rx  in  1  serial input, asynchronous
rx_data  out  DATA_BITS  received word
rx_valid  out  1  one-cycle pulse when rx_data and the error flags are valid
rx_parity_err  out  1  parity mismatch, qualified by rx_valid
rx_frame_err  out  1  a stop bit sampled low, qualified by rx_valid

Behaviour:
- Reset values: tx=1, tx_ready=1, tx_done=0, rx_valid=0, rx_data=0, both error flags 0.
- Reset taken mid-frame aborts both FSMs to IDLE immediately. No partial word is reported.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer truncation.
  - Counter runs 0..DIV-1 and asserts tick for one clk on wrap.
  - Free-running; cleared only by rst.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - Handshake: a word is accepted on a clk where tx_valid && tx_ready. tx_data is latched and tx_ready drops on the next clk.
  - The start bit begins on the first tick after acceptance. Each bit lasts exactly OVERSAMPLE ticks.
  - Data is sent LSB first.
  - PARITY state is skipped when PARITY=0. The parity bit is XOR of the data (even) or its inverse (odd).
  - STOP holds tx=1 for STOP_BITS bit times.
  - On STOP completion: tx_done pulses and tx_ready rises in the same clk. The FSM returns to IDLE.
  - Back-to-back words incur no idle bit beyond tick alignment.
  - tx_valid while tx_ready=0 is ignored. The client must hold it.
- RX path:
  - rx passes through a 2-FF synchroniser before use.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised falling edge enters START, with the tick count cleared.
  - START: rx is resampled after OVERSAMPLE/2 ticks. If high, this is a false start: return to IDLE with no report. If low, proceed.
  - Each later bit is sampled every OVERSAMPLE ticks from there (bit centre). Data is shifted LSB first.
  - PARITY state exists only when PARITY≠0. It records the mismatch.
  - STOP samples STOP_BITS bits. Any low sample sets the frame error.
  - At the centre of the last stop bit: rx_valid pulses for one clk with rx_data and both error flags. Then the FSM returns to IDLE, ready for the next falling edge.
  - Words with errors are still delivered; the flags mark them. Flags hold until the next rx_valid.
  - A line held low (break) yields one frame-error word. No new start is detected until rx returns high.
- TX and RX may be active simultaneously with no interaction.

Optional Feature:
UART_LOOPBACK_EN.
- When defined: an extra input port loopback (1 bit) is added.
  - When loopback=1, the RX synchroniser input is the internal tx, and the tx pin is forced to 1.
  - Switching loopback mid-frame is allowed; the in-flight RX frame may error.
- When undefined: no port is added, and rx feeds the synchroniser directly.

Decomposition:
- Package uart_pkg:
  - parity_e (PAR_NONE, PAR_ODD, PAR_EVEN)
  - tx_state_e and rx_state_e
  - function computing DIV from CLK_FREQ/BAUD_RATE/OVERSAMPLE
- Sub-module uart_baud_gen: parameter DIV, ports clk, rst, tick.

Test Plan:
Use CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
1. 8N1, send 0xA5 -> tx bits low, 1,0,1,0,0,1,0,1, high, each 160 clk. tx_done pulses once. tx_ready low for the whole frame.
2. DATA_BITS=7, PARITY=2, STOP_BITS=2, bench drives rx frame data 0x35 with parity 0 -> rx_valid pulse with rx_data=0x35 and both error flags 0. Repeat with parity 1 -> rx_parity_err=1.
3. Drive rx frame for 0x3C with stop bit low -> rx_valid with rx_data=0x3C and rx_frame_err=1. A next clean frame of 0x81 -> flags clear.
4. A 40-clk low glitch on rx -> no rx_valid. The following valid frame of 0x55 is received correctly.
5. Assert rst mid-data-bit of a TX frame -> tx=1 and tx_ready=1 next clk. A new word 0x0F then transmits a clean full frame.
6. Full duplex: transmit 0x12 while receiving 0xEF -> both complete correctly. With UART_LOOPBACK_EN and loopback=1, sending 0x7E -> rx_valid with 0x7E, and the tx pin stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity modes, TX/RX state encodings and the tick divider.
// DIV is clamped to 1 so the baud generator never stalls on an over-fast baud.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  function automatic int uart_div(int clk_freq, int baud_rate, int oversample);
    int div = clk_freq / (baud_rate * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Client-side UART bus: valid/ready TX word channel, pulsed RX word channel.
// The master is the byte-stream client; the slave is uart_ctrl.
interface uart_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick: one-clk pulse every DIV clocks, no backpressure.
// Counter is cleared only by reset, so TX and RX share one phase.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_ctrl.sv
// Full-duplex UART (configurable width/parity/stop); TX word starts on first tick after accept, tx_ready low for the frame.
// RX reports at the centre of the last stop bit, no backpressure. `UART_LOOPBACK_EN adds a loopback input.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic  clk,
  input  logic  rst,
  uart_if.slave bus,
  output logic  tx,
  input  logic  rx
`ifdef UART_LOOPBACK_EN
  ,
  input  logic  loopback
`endif
);
  localparam int              DIV      = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int              OSW      = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0]  OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0]  OS_HALF  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]      SB_LAST  = 4'(STOP_BITS - 1);
  localparam bit              PAR_EN   = (PARITY != PAR_NONE);
  localparam bit              PAR_ODDM = (PARITY == PAR_ODD);

  logic tick;
  logic tx_int, rx_src;

  uart_baud_gen #(.DIV(DIV)) u_baud (.clk(clk), .rst(rst), .tick(tick));

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_int : rx;
  assign tx     = loopback ? 1'b1   : tx_int;
`else
  assign rx_src = rx;
  assign tx     = tx_int;
`endif

  // ---------------- transmitter ----------------
  tx_state_e            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [OSW-1:0]       tx_cnt;
  logic [3:0]           tx_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      tx_int       <= 1'b1;
      tx_shift     <= '0;
      tx_par       <= 1'b0;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      bus.tx_ready <= 1'b1;
      bus.tx_done  <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          // tx_ready low while idle means a word is latched and waiting for tick alignment
          if (!bus.tx_ready) begin
            if (tick) begin
              tx_int   <= 1'b0;
              tx_cnt   <= '0;
              tx_state <= TX_START;
            end
          end else if (bus.tx_valid) begin
            tx_shift     <= bus.tx_data;
            tx_par       <= (^bus.tx_data) ^ PAR_ODDM;
            bus.tx_ready <= 1'b0;
          end
        end
        default: if (tick) begin
          if (tx_cnt != OS_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            case (tx_state)
              TX_START: begin
                tx_int   <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_bit   <= '0;
                tx_state <= TX_DATA;
              end
              TX_DATA: begin
                if (tx_bit == DB_LAST) begin
                  tx_bit   <= '0;
                  tx_int   <= PAR_EN ? tx_par : 1'b1;
                  tx_state <= PAR_EN ? TX_PARITY : TX_STOP;
                end else begin
                  tx_int   <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= tx_bit + 1'b1;
                end
              end
              TX_PARITY: begin
                tx_int   <= 1'b1;
                tx_state <= TX_STOP;
              end
              default: begin
                if (tx_bit == SB_LAST) begin
                  bus.tx_done  <= 1'b1;
                  bus.tx_ready <= 1'b1;
                  tx_state     <= TX_IDLE;
                end else begin
                  tx_bit <= tx_bit + 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_e            rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [OSW-1:0]       rx_cnt;
  logic [3:0]           rx_bit;
  logic                 rx_perr, rx_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state          <= RX_IDLE;
      rx_shift          <= '0;
      rx_cnt            <= '0;
      rx_bit            <= '0;
      rx_perr           <= 1'b0;
      rx_ferr           <= 1'b0;
      bus.rx_valid      <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      case (rx_state)
        // edge-triggered so a held-low line cannot restart until it has gone high again
        RX_IDLE: if (rx_prev && !rx_sync) begin
          rx_cnt   <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (tick) begin
          if (rx_cnt != OS_HALF) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_bit   <= '0;
              rx_perr  <= 1'b0;
              rx_ferr  <= 1'b0;
              rx_state <= RX_DATA;
            end
          end
        end
        default: if (tick) begin
          if (rx_cnt != OS_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            case (rx_state)
              RX_DATA: begin
                rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                if (rx_bit == DB_LAST) begin
                  rx_bit   <= '0;
                  rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
                end else begin
                  rx_bit <= rx_bit + 1'b1;
                end
              end
              RX_PARITY: begin
                rx_perr  <= rx_sync ^ (^rx_shift) ^ PAR_ODDM;
                rx_state <= RX_STOP;
              end
              default: begin
                if (rx_bit == SB_LAST) begin
                  bus.rx_valid      <= 1'b1;
                  bus.rx_data       <= rx_shift;
                  bus.rx_parity_err <= rx_perr;
                  bus.rx_frame_err  <= rx_ferr | ~rx_sync;
                  rx_state          <= RX_IDLE;
                end else begin
                  rx_ferr <= rx_ferr | ~rx_sync;
                  rx_bit  <= rx_bit + 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule
